// File: rtl/spimem_arb.sv
// spimem_arb: two-port round-robin arbiter onto one SPI flash controller, with bounded sequential bursts
module spimem_arb #(
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_valid,
  input  logic [23:0] p0_addr,
  output logic        p0_ready,
  output logic [31:0] p0_rdata,
  input  logic        p1_valid,
  input  logic [23:0] p1_addr,
  output logic        p1_ready,
  output logic [31:0] p1_rdata,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] BMAX = 4'(BURST_MAX);
  state_t      state, state_nx;
  logic        rr_ptr, rr_nx, last_valid, lv_nx, owner_nx, winner, cont, active, own_valid;
  logic [21:0] last_addr, la_nx;
  logic [3:0]  burst_cnt, bc_nx;
  logic [23:0] own_addr;
  assign own_valid = owner ? p1_valid : p0_valid;
  assign own_addr  = owner ? p1_addr : p0_addr;
  assign cont      = last_valid && own_valid && own_addr[23:2] == last_addr + 22'd1 && burst_cnt < BMAX;
  assign winner    = (p0_valid && p1_valid) ? rr_ptr : p1_valid;
  // gating with resetn keeps a mem_ready seen during reset from reaching either port
  assign active    = resetn && state == BUSY;
  assign busy      = active;
  assign mem_valid = active && own_valid;
  assign mem_addr  = own_addr;
  assign p0_ready  = active && !owner && mem_ready;
  assign p1_ready  = active && owner && mem_ready;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    lv_nx    = last_valid;
    la_nx    = last_addr;
    bc_nx    = burst_cnt;
    if (state == IDLE) begin
      if (cont) state_nx = BUSY;
      else if (p0_valid || p1_valid) begin
        state_nx = BUSY;
        owner_nx = winner;
        rr_nx    = ~winner;
        bc_nx    = '0;
      end
    end else if (mem_ready) begin
      state_nx = IDLE;
      la_nx    = own_addr[23:2];
      lv_nx    = 1'b1;
      bc_nx    = burst_cnt == 4'hf ? burst_cnt : burst_cnt + 4'd1;
    end else if (!own_valid) begin
      state_nx = IDLE;
      lv_nx    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      burst_cnt  <= '0;
      last_valid <= 1'b0;
      last_addr  <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      rr_ptr     <= rr_nx;
      burst_cnt  <= bc_nx;
      last_valid <= lv_nx;
      last_addr  <= la_nx;
    end
  end
endmodule

// File: tb/tb_spimem_arb.sv
// tb_spimem_arb: randomized and directed checks of spimem_arb against a transaction-level model
module tb_spimem_arb;
  localparam int BMAX = 8;
  localparam int WMASK = 'h3FFFFF;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        resetn, p0_valid, p1_valid, mem_ready;
  logic [23:0] p0_addr, p1_addr, mem_addr;
  logic [31:0] mem_rdata, p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready, mem_valid, busy, owner;
  spimem_arb #(.BURST_MAX(BMAX)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // stimulus state
  bit rst_n, mr;
  bit pv[2];
  int pa[2], nxt[2], gap[2];
  int md, lat;
  // reference model: a granted port, preferred port, last completed word and run length
  bit m_busy, m_owner, m_pref, m_have;
  int m_last, m_run;
  bit e_rdy[2], o_rdy[2];
  bit o_mv, o_own;
  function automatic bit e_mv();
    return rst_n && m_busy && pv[m_owner];
  endfunction
  task automatic step();
    bit act, seq;
    int w;
    resetn = rst_n;
    p0_valid = pv[0];
    p0_addr = pa[0][23:0];
    p1_valid = pv[1];
    p1_addr = pa[1][23:0];
    mem_ready = mr;
    mem_rdata = md;
    #1;
    act = rst_n && m_busy;
    o_rdy[0] = p0_ready;
    o_rdy[1] = p1_ready;
    o_mv = mem_valid;
    o_own = owner;
    chk("busy", busy, act);
    if (rst_n) chk("owner", owner, m_owner);
    chk("mem_valid", mem_valid, e_mv());
    if (e_mv()) chk("mem_addr", mem_addr, pa[m_owner]);
    for (int i = 0; i < 2; i++) begin
      e_rdy[i] = act && m_owner == i && mr;
      chk(i ? "p1_ready" : "p0_ready", i ? p1_ready : p0_ready, e_rdy[i]);
      if (e_rdy[i]) chk(i ? "p1_rdata" : "p0_rdata", i ? p1_rdata : p0_rdata, md);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_pref = 0; m_run = 0; m_have = 0; m_last = 0;
    end else if (!m_busy) begin
      seq = m_have && pv[m_owner] && (pa[m_owner] >> 2) == ((m_last + 1) & WMASK) && m_run < BMAX;
      if (seq) m_busy = 1;
      else if (pv[0] || pv[1]) begin
        w = (pv[0] && pv[1]) ? int'(m_pref) : int'(pv[1]);
        m_owner = w[0];
        m_pref = !w[0];
        m_run = 0;
        m_busy = 1;
      end
    end else if (mr) begin
      m_last = pa[m_owner] >> 2;
      m_have = 1;
      m_run = m_run < 15 ? m_run + 1 : 15;
      m_busy = 0;
    end else if (!pv[m_owner]) begin
      m_busy = 0;
      m_have = 0;
    end
    #1;
  endtask
  task automatic tick(input int maxlat);
    mr = 0;
    if (e_mv()) begin
      if (lat == 0) begin
        mr = 1;
        lat = $urandom_range(0, maxlat);
      end else lat--;
    end
    md = $urandom;
    step();
  endtask
  task automatic do_reset();
    rst_n = 0; mr = 0; pv[0] = 0; pv[1] = 0; gap[0] = 0; gap[1] = 0; lat = 0;
    repeat (2) begin
      md = $urandom;
      step();
    end
    rst_n = 1;
  endtask
  task automatic rand_phase(input int n, input int seqpct, input int wdpct, input int maxlat);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (e_rdy[i]) begin
          pv[i] = 0;
          nxt[i] = ((pa[i] & 'hFFFFFC) + 4) & 'hFFFFFF;
          gap[i] = $urandom_range(0, 1);
        end else if (pv[i] && $urandom_range(0, 99) < wdpct) begin
          pv[i] = 0;
          gap[i] = 1;
        end
        if (!pv[i] && rst_n) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            pv[i] = 1;
            if ($urandom_range(0, 99) < seqpct) pa[i] = nxt[i] | $urandom_range(0, 3);
            else if ($urandom_range(0, 9) == 0) pa[i] = 'hFFFFFC;
            else pa[i] = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
          end
        end
      end
      rst_n = $urandom_range(0, 299) != 0;
      tick(maxlat);
    end
    rst_n = 1;
  endtask
  initial begin
    int first_mv, rdy_k, n, run, max_run;
    logic [2:0] order;
    rst_n = 0; mr = 0; md = 0; lat = 0;
    pv[0] = 1; pv[1] = 1; pa[0] = 'h100; pa[1] = 'h200;
    m_busy = 0; m_owner = 0; m_pref = 0; m_have = 0; m_last = 0; m_run = 0;
    e_rdy[0] = 0; e_rdy[1] = 0;
    #1;
    repeat (2) begin
      md = $urandom;
      step();
    end
    do_reset();
    // single port, long flash latency
    pv[0] = 1; pa[0] = 'h100; lat = 19; first_mv = -1; rdy_k = -1; n = 0;
    for (int k = 0; k < 40; k++) begin
      if (e_rdy[0]) pv[0] = 0;
      tick(19);
      if (o_mv && first_mv < 0) first_mv = k;
      if (o_rdy[0]) begin
        n++;
        rdy_k = k;
      end
    end
    chk("lat_first_mv", first_mv, 1);
    chk("lat_ready_cycle", rdy_k, 20);
    chk("lat_ready_count", n, 1);
    // contention right after reset
    do_reset();
    pv[0] = 1; pv[1] = 1; pa[0] = 'h100; pa[1] = 'h200; order = '0; n = 0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      tick(2);
      if (o_rdy[0] || o_rdy[1]) begin
        order = {order[1:0], o_rdy[1]};
        n++;
      end
    end
    chk("contend_count", n, 3);
    chk("contend_order", 32'(order), 32'b010);
    // p1 streams sequentially while p0 waits
    do_reset();
    pv[0] = 1; pv[1] = 1; pa[0] = 'h100; pa[1] = 0; run = 0; max_run = 0;
    for (int k = 0; k < 400; k++) begin
      if (e_rdy[1]) pa[1] = (pa[1] + 4) & 'hFFFFFF;
      tick(2);
      if (o_rdy[1]) begin
        run++;
        if (run > max_run) max_run = run;
      end
      if (o_rdy[0]) run = 0;
    end
    chk("burst_max_run", max_run, BMAX);
    // non-sequential p1 access lets p0 in
    do_reset();
    pv[0] = 0; pv[1] = 1; pa[1] = 'h10; order = '0; n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      if (e_rdy[1]) pa[1] = 'h20;
      if (k == 2) begin
        pv[0] = 1;
        pa[0] = 'h300;
      end
      tick(1);
      if (o_rdy[0] || o_rdy[1]) begin
        order = {order[1:0], o_rdy[1]};
        n++;
      end
    end
    chk("nonseq_order", 32'(order), 32'b101);
    // withdrawal hands over to a pending p1
    do_reset();
    pv[0] = 1; pa[0] = 'h100; lat = 50;
    for (int k = 0; k < 10 && !m_busy; k++) tick(50);
    pv[0] = 0; pv[1] = 1; pa[1] = 'h204; mr = 0;
    step();
    chk("wd_idle_busy", busy, 0);
    tick(50);
    tick(50);
    chk("wd_p1_granted", {o_mv, o_own}, 2'b11);
    // reset while busy with mem_ready high
    do_reset();
    pv[1] = 0; pv[0] = 1; pa[0] = 'h40; lat = 50;
    for (int k = 0; k < 10 && !m_busy; k++) tick(50);
    rst_n = 0; mr = 1; md = $urandom;
    step();
    chk("rst_busy_no_ready", {o_rdy[0], o_rdy[1]}, 0);
    rst_n = 1; mr = 0; pa[0] = 'h80; lat = 0;
    tick(0);
    tick(0);
    chk("post_rst_grant", {o_mv, o_own, o_rdy[0]}, 3'b101);
    // randomized traffic
    pv[0] = 0; pv[1] = 0;
    rand_phase(1500, 80, 0, 3);
    rand_phase(1500, 50, 10, 4);
    rand_phase(1500, 90, 5, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spimem_arb.md
SPIMEM_ARB -- requirements
Module: spimem_arb

Interface
REQ-001 Parameter: BURST_MAX, default 8, maximum consecutive sequential words granted to one port before it must yield to the other port (range 1..15).
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 p0_valid  input  1  port 0 (CPU fetch) request; held with p0_addr stable until p0_ready or withdrawn.
REQ-005 p0_addr  input  24  port 0 byte address; bits [1:0] ignored.
REQ-006 p0_ready  output  1  port 0 completion strobe, one cycle.
REQ-007 p0_rdata  output  32  port 0 read data, valid while p0_ready=1.
REQ-008 p1_valid, p1_addr, p1_ready, p1_rdata  same directions, widths and meanings as the p0_ signals, for port 1 (DMA).
REQ-009 mem_valid  output  1  request to the SPI flash memory controller.
REQ-010 mem_addr  output  24  address to the flash controller.
REQ-011 mem_ready  input  1  completion from the flash controller; may be combinational from mem_valid/mem_addr.
REQ-012 mem_rdata  input  32  flash read data, valid while mem_ready=1.
REQ-013 busy  output  1  high while a grant is held (state BUSY).
REQ-014 owner  output  1  port currently or last granted (0 or 1).

Function
REQ-015 State machine has two states, IDLE and BUSY, plus registers: owner (1b), rr_ptr (1b, preferred port), last_addr (22b, word address of last completed word), burst_cnt (4b), last_valid (1b).
REQ-016 IDLE: mem_valid=0; p0_ready=0; p1_ready=0.
REQ-017 IDLE with no p*_valid: remain IDLE; no register changes.
REQ-018 IDLE burst rule: a burst continuation exists when last_valid=1, port[owner]_valid=1, port[owner]_addr[23:2]==last_addr+1 (22-bit wrap, 0x3FFFFF+1=0), and burst_cnt<BURST_MAX.
REQ-019 IDLE with a burst continuation: next state BUSY; owner unchanged; burst_cnt unchanged; rr_ptr unchanged.
REQ-020 IDLE without a burst continuation, only one port valid: grant that port.
REQ-021 IDLE without a burst continuation, both ports valid: grant the port equal to rr_ptr.
REQ-022 On a non-burst grant (REQ-020/021): owner set to the winner; burst_cnt cleared to 0; rr_ptr set to ~winner; next state BUSY.
REQ-023 BUSY: mem_valid=port[owner]_valid; mem_addr=port[owner]_addr; port[owner]_ready=mem_ready; port[owner]_rdata=mem_rdata; the other port's ready=0.
REQ-024 The non-owner port's rdata output is driven with mem_rdata; it is only meaningful while that port's ready=1.
REQ-025 Grant latency: a request in IDLE gives mem_valid=1 on the next cycle, i.e. one cycle after p*_valid rises.
REQ-026 BUSY and mem_ready=1: last_addr<=mem_addr[23:2]; last_valid<=1; burst_cnt<=burst_cnt+1, saturating at 15; next state IDLE.
REQ-027 BUSY with port[owner]_valid=0 and no mem_ready (requester withdrew): next state IDLE; last_valid<=0; burst_cnt unchanged.
REQ-028 No preemption: while BUSY, a request on the non-owner port has no effect until return to IDLE.
REQ-029 BURST_MAX reached: in IDLE the continuation is refused. If the other port is valid, the other port is granted. If the other port is idle, the same port is re-granted as a non-burst grant with burst_cnt=0.
REQ-030 A non-sequential address on the owner port (including a repeat of last_addr) is never a continuation; it is arbitrated per REQ-020/021.
REQ-031 busy=1 exactly in BUSY.
REQ-032 owner is the registered owner value.
REQ-033 mem_valid is never asserted in the same cycle as a state change from IDLE.

Reset
REQ-034 resetn=0 at a rising edge: state<=IDLE; owner<=0; rr_ptr<=0; burst_cnt<=0; last_valid<=0; last_addr<=0.
REQ-035 During reset and the cycle after: mem_valid=0; p0_ready=0; p1_ready=0; busy=0.
REQ-036 Reset asserted mid-transaction (BUSY): the transaction is abandoned; a mem_ready arriving in the reset cycle is not forwarded and does not update registers.

Verification
REQ-037 Single port: p0 reads 0x000100 with flash latency 20 cycles -> mem_valid rises 1 cycle after p0_valid; p0_ready for one cycle with p0_rdata=mem_rdata; busy falls the next cycle.
REQ-038 Contention after reset: p0 and p1 valid in the same cycle -> p0 granted first (rr_ptr=0), then p1, then p0; owner output toggles 0,1,0.
REQ-039 Burst: p1 streams 0x000000,0x000004,... while p0 is continuously valid, BURST_MAX=8 -> p1 completes 8 words (one grant plus 7 continuations), then p0 is granted.
REQ-040 Non-sequential access: p1 reads 0x000010 then 0x000020 while p0 is valid -> the second p1 access is not a continuation and p0 is granted in between.
REQ-041 Withdrawal: p0 drops valid in BUSY before mem_ready -> return to IDLE; last_valid=0; a pending p1 is granted on the following IDLE cycle.
REQ-042 Reset in BUSY: resetn low for 1 cycle while mem_ready=1 -> no p*_ready pulse; all registers at REQ-034 values; a new p0 request is granted normally afterwards.
